// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and segment patterns for the time display.
// Patterns are active-low, bit order [6:0] = g,f,e,d,c,b,a.
package seg7_pkg;

  localparam int NUM_DIGITS = 6;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD nibble to active-low segment pattern.
// Ports: digit (4-bit BCD in), seg (7-bit g..a out); 10-15 show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  bcd_digit_t  digit,
  output logic [6:0]  seg
);

  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_time_scan.sv
// seg7_time_scan: 6-digit multiplexed HH:MM:SS common-anode driver.
// Ports: clk, reset (async low), sec/min/hour (packed BCD),
// blink_mask, dp_mask (per digit), an/seg/dp (active-low), frame pulse.
module seg7_time_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 83
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sec,
  input  logic [7:0] min,
  input  logic [7:0] hour,
  input  logic [5:0] blink_mask,
  input  logic [5:0] dp_mask,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [2:0] LAST = 3'(NUM_DIGITS - 1);

  logic [DW-1:0] div;
  logic [2:0]    idx;
  logic          valid;
  logic          phase;
  logic [FW-1:0] fcnt;

  bcd_digit_t [NUM_DIGITS-1:0] sh_dig;
  logic [5:0] sh_blink;
  logic [5:0] sh_dp;

  logic       tick;
  logic       snap;
  logic       blank;
  logic [6:0] dec;

  assign tick  = (div == DW'(SCAN_DIV - 1));
  assign snap  = tick && (idx == LAST);
  assign blank = phase && sh_blink[idx];

  bcd_to_seg7 u_dec (
    .digit (sh_dig[idx]),
    .seg   (dec)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= '0;
      idx <= LAST;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick)
        idx <= (idx == LAST) ? 3'd0 : idx + 3'd1;
    end
  end

  // The blink counter counts completed frames, so the very first
  // snapshot (nothing displayed yet) does not advance it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid    <= 1'b0;
      frame    <= 1'b0;
      phase    <= 1'b0;
      fcnt     <= '0;
      sh_dig   <= '0;
      sh_blink <= '0;
      sh_dp    <= '0;
    end else begin
      frame <= snap;
      if (snap) begin
        valid    <= 1'b1;
        sh_dig   <= {hour, min, sec};
        sh_blink <= blink_mask;
        sh_dp    <= dp_mask;
        if (valid) begin
          if (fcnt == FW'(BLINK_FRAMES - 1)) begin
            fcnt  <= '0;
            phase <= ~phase;
          end else begin
            fcnt <= fcnt + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= 6'h3F;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else if (valid && !blank) begin
      an  <= ~(6'b1 << idx);
      seg <= dec;
      dp  <= ~sh_dp[idx];
    end else begin
      an  <= 6'h3F;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_time_scan.sv
// tb_seg7_time_scan: directed bench for seg7_time_scan.
// SCAN_DIV = 4, BLINK_FRAMES = 2.
module tb_seg7_time_scan;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] sec = 8'h00;
  logic [7:0] min = 8'h00;
  logic [7:0] hour = 8'h00;
  logic [5:0] blink_mask = '0;
  logic [5:0] dp_mask = '0;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame;

  int tests = 0;
  int fails = 0;
  int cnt = 0;

  seg7_time_scan #(
    .SCAN_DIV     (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sec        (sec),
    .min        (min),
    .hour       (hour),
    .blink_mask (blink_mask),
    .dp_mask    (dp_mask),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame      (frame)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] pat(input logic [3:0] n);
    case (n)
      4'd0: pat = 7'b1000000;
      4'd1: pat = 7'b1111001;
      4'd2: pat = 7'b0100100;
      4'd3: pat = 7'b0110000;
      4'd4: pat = 7'b0011001;
      4'd5: pat = 7'b0010010;
      4'd6: pat = 7'b0000010;
      4'd7: pat = 7'b1111000;
      4'd8: pat = 7'b0000000;
      4'd9: pat = 7'b0010000;
      default: pat = 7'b0111111;
    endcase
  endfunction

  function automatic logic [3:0] nib(input logic [23:0] t, input int d);
    logic [23:0] s;
    s = t >> (4 * d);
    nib = s[3:0];
  endfunction

  function automatic int dig_of(input int c);
    dig_of = ((c - 5) / 4) % 6;
  endfunction

  function automatic logic [5:0] cold(input int d);
    cold = ~(6'b1 << d);
  endfunction

  task automatic step();
    @(posedge clk);
    cnt++;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [7:0] h, input logic [7:0] m,
                          input logic [7:0] s, input logic [5:0] bm,
                          input logic [5:0] dm);
    @(negedge clk);
    reset = 1'b0;
    hour = h; min = m; sec = s;
    blink_mask = bm; dp_mask = dm;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    cnt = 0;
  endtask

  task automatic test_reset();
    logic [23:0] t;
    logic [5:0]  ea;
    logic [6:0]  es;
    logic        ef;
    t = 24'h123456;
    @(negedge clk);
    reset = 1'b0;
    hour = 8'h12; min = 8'h34; sec = 8'h56;
    blink_mask = '0; dp_mask = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (an !== 6'h3F || seg !== 7'h7F || dp !== 1'b1 || frame !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold an=%h seg=%h dp=%b fr=%b want 3f/7f/1/0",
                 an, seg, dp, frame);
      end
    end
    reset = 1'b1;
    cnt = 0;
    while (cnt < 30) begin
      step();
      ef = (cnt >= 4) && ((cnt - 4) % 24 == 0);
      ea = (cnt < 5) ? 6'h3F : cold(dig_of(cnt));
      es = (cnt < 5) ? 7'h7F : pat(nib(t, dig_of(cnt)));
      tests++;
      if (frame !== ef) begin
        fails++;
        $display("FAIL first_frame_pulse cyc=%0d got=%b want=%b", cnt, frame, ef);
      end
      tests++;
      if (an !== ea || seg !== es) begin
        fails++;
        $display("FAIL first_frame_scan cyc=%0d an=%b seg=%b want %b %b",
                 cnt, an, seg, ea, es);
      end
      tests++;
      if ($countones(~an) > 1) begin
        fails++;
        $display("FAIL onehot cyc=%0d an=%b want at most one low", cnt, an);
      end
    end
  endtask

  task automatic test_snapshot();
    do_reset(8'h12, 8'h34, 8'h56, '0, '0);
    while (cnt < 6) step();
    sec = 8'h57;
    while (cnt < 12) begin
      step();
      tests++;
      if (cnt <= 8) begin
        if (an !== 6'b111110 || seg !== pat(4'd6)) begin
          fails++;
          $display("FAIL snap_hold cyc=%0d an=%b seg=%b want 111110 %b",
                   cnt, an, seg, pat(4'd6));
        end
      end else begin
        if (an !== 6'b111101 || seg !== pat(4'd5)) begin
          fails++;
          $display("FAIL snap_tens cyc=%0d an=%b seg=%b want 111101 %b",
                   cnt, an, seg, pat(4'd5));
        end
      end
    end
    while (cnt < 28) step();
    while (cnt < 32) begin
      step();
      tests++;
      if (an !== 6'b111110 || seg !== pat(4'd7)) begin
        fails++;
        $display("FAIL snap_next cyc=%0d an=%b seg=%b want 111110 %b",
                 cnt, an, seg, pat(4'd7));
      end
    end
  endtask

  task automatic test_invalid_bcd();
    do_reset(8'h12, 8'h34, 8'hA9, '0, '0);
    while (cnt < 12) begin
      step();
      if (cnt >= 5) begin
        tests++;
        if (cnt <= 8) begin
          if (an !== 6'b111110 || seg !== 7'b0010000) begin
            fails++;
            $display("FAIL bcd_nine cyc=%0d an=%b seg=%b want 111110 0010000",
                     cnt, an, seg);
          end
        end else begin
          if (an !== 6'b111101 || seg !== 7'b0111111) begin
            fails++;
            $display("FAIL bcd_dash cyc=%0d an=%b seg=%b want 111101 0111111",
                     cnt, an, seg);
          end
        end
      end
    end
  endtask

  task automatic test_blink();
    logic [23:0] t;
    int d, f;
    logic bl;
    logic [5:0] ea;
    logic [6:0] es;
    t = 24'h123456;
    do_reset(8'h12, 8'h34, 8'h56, 6'b000011, '0);
    while (cnt < 5 + 24 * 5) begin
      step();
      if (cnt >= 5) begin
        d  = dig_of(cnt);
        f  = (cnt - 5) / 24;
        bl = (((f / 2) % 2) == 1) && (d < 2);
        ea = bl ? 6'h3F : cold(d);
        es = bl ? 7'h7F : pat(nib(t, d));
        tests++;
        if (an !== ea || seg !== es || dp !== 1'b1) begin
          fails++;
          $display("FAIL blink frm=%0d dig=%0d an=%b seg=%b dp=%b want %b %b 1",
                   f + 1, d, an, seg, dp, ea, es);
        end
      end
    end
  endtask

  task automatic test_dp();
    int d;
    logic ed;
    do_reset(8'h12, 8'h34, 8'h56, '0, 6'b010100);
    while (cnt < 5 + 48) begin
      step();
      d  = (cnt >= 5) ? dig_of(cnt) : -1;
      ed = !(d == 2 || d == 4);
      tests++;
      if (dp !== ed) begin
        fails++;
        $display("FAIL dp cyc=%0d an=%b dp=%b want %b", cnt, an, dp, ed);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic ef;
    logic [5:0] ea;
    do_reset(8'h12, 8'h34, 8'h56, '0, 6'b111111);
    while (cnt < 18) step();
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if (an !== 6'h3F || seg !== 7'h7F || dp !== 1'b1 || frame !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset an=%h seg=%h dp=%b fr=%b want 3f/7f/1/0",
               an, seg, dp, frame);
    end
    @(negedge clk);
    tests++;
    if (an !== 6'h3F || seg !== 7'h7F || frame !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_hold an=%h seg=%h fr=%b want 3f/7f/0",
               an, seg, frame);
    end
    @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    while (cnt < 13) begin
      step();
      ef = (cnt == 4);
      ea = (cnt < 5) ? 6'h3F : cold(dig_of(cnt));
      tests++;
      if (frame !== ef || an !== ea) begin
        fails++;
        $display("FAIL mid_reset_restart cyc=%0d an=%b fr=%b want %b %b",
                 cnt, an, frame, ea, ef);
      end
    end
  endtask

  initial begin
    test_reset();
    test_snapshot();
    test_invalid_bcd();
    test_blink();
    test_dp();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
